// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: write/scan/readback controller for the DE1_SoC 32x4 RAM.
// Optional readback check built when RAM_ACCESS_VERIFY_EN is defined.
//
// Ports:
//   clk_i         system clock
//   reset_i       synchronous, active-high reset
//   key_n_i       raw write push-button, active-low
//   sw_addr_i     raw switch write address
//   sw_data_i     raw switch write data
//   ram_q_i       RAM read data (unused without RAM_ACCESS_VERIFY_EN)
//   ram_wraddr_o  RAM write address, valid while ram_wren_o
//   ram_wrdata_o  RAM write data, valid while ram_wren_o
//   ram_wren_o    RAM write enable, one-cycle pulse per write
//   ram_rdaddr_o  RAM read address (scan, or written word during readback)
//   scan_addr_o   auto-scanning address for the display stage
//   wr_done_o     one-cycle pulse when a write transaction completes
//   wr_count_o    completed writes since reset, wraps 255->0
//   verify_err_o  sticky readback mismatch flag (0 without the macro)
`timescale 1ns/1ps

module ram_access_ctrl #(
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 4,
   parameter int TICK_DIV    = 50000000,
   parameter int RD_LAT      = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              key_n_i,
   input  logic [ADDR_W-1:0] sw_addr_i,
   input  logic [DATA_W-1:0] sw_data_i,
   input  logic [DATA_W-1:0] ram_q_i,
   output logic [ADDR_W-1:0] ram_wraddr_o,
   output logic [DATA_W-1:0] ram_wrdata_o,
   output logic              ram_wren_o,
   output logic [ADDR_W-1:0] ram_rdaddr_o,
   output logic [ADDR_W-1:0] scan_addr_o,
   output logic              wr_done_o,
   output logic [7:0]        wr_count_o,
   output logic              verify_err_o
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1
`ifdef RAM_ACCESS_VERIFY_EN
      ,
      ST_RDWAIT = 2'd2,
      ST_CHECK  = 2'd3
`endif
   } state_t;

   // ---------------------------------------------------------------
   // Input synchronizers and key edge detect
   // ---------------------------------------------------------------
   logic [SYNC_STAGES-1:0]             key_sync_q;
   logic [SYNC_STAGES-1:0][ADDR_W-1:0] addr_sync_q;
   logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync_q;
   logic [SYNC_STAGES-1:0]             vld_q;
   logic                               key_prev_q;

   logic              key_s;
   logic [ADDR_W-1:0] addr_s;
   logic [DATA_W-1:0] data_s;
   logic              press;

   assign key_s  = key_sync_q[SYNC_STAGES-1];
   assign addr_s = addr_sync_q[SYNC_STAGES-1];
   assign data_s = data_sync_q[SYNC_STAGES-1];

   // The synchronizer's reset value is not a real sample of the button.
   // vld_q marks when real samples reach the output, so a key held low
   // through reset never looks like a release followed by a press.
   assign press = key_prev_q & ~key_s;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         key_sync_q  <= '1;
         addr_sync_q <= '0;
         data_sync_q <= '0;
         vld_q       <= '0;
         key_prev_q  <= 1'b0;
      end else begin
         key_sync_q  <= {key_sync_q[SYNC_STAGES-2:0], key_n_i};
         addr_sync_q <= {addr_sync_q[SYNC_STAGES-2:0], sw_addr_i};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], sw_data_i};
         vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         key_prev_q  <= key_s & vld_q[SYNC_STAGES-1];
      end
   end

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   state_t            state_q,    state_d;
   logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0] lat_data_q, lat_data_d;
   logic [TW-1:0]     tick_q,     tick_d;
   logic [ADDR_W-1:0] scan_q,     scan_d;
   logic [7:0]        cnt_q,      cnt_d;

   logic              wren_c;
   logic [ADDR_W-1:0] wraddr_c;
   logic [DATA_W-1:0] wrdata_c;
   logic [ADDR_W-1:0] rdaddr_c;
   logic              done_c;

`ifdef RAM_ACCESS_VERIFY_EN
   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

   logic [LW-1:0] lat_cnt_q, lat_cnt_d;
   logic          err_q,     err_d;
`else
   logic unused_ram_q;
   assign unused_ram_q = ^ram_q_i;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         lat_addr_q <= '0;
         lat_data_q <= '0;
         tick_q     <= '0;
         scan_q     <= '0;
         cnt_q      <= '0;
`ifdef RAM_ACCESS_VERIFY_EN
         lat_cnt_q  <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         lat_addr_q <= lat_addr_d;
         lat_data_q <= lat_data_d;
         tick_q     <= tick_d;
         scan_q     <= scan_d;
         cnt_q      <= cnt_d;
`ifdef RAM_ACCESS_VERIFY_EN
         lat_cnt_q  <= lat_cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   // ---------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      lat_addr_d = lat_addr_q;
      lat_data_d = lat_data_q;
      tick_d     = tick_q + TW'(1);
      scan_d     = scan_q;
      cnt_d      = cnt_q;
`ifdef RAM_ACCESS_VERIFY_EN
      lat_cnt_d  = lat_cnt_q;
      err_d      = err_q;
`endif
      wren_c     = 1'b0;
      wraddr_c   = '0;
      wrdata_c   = '0;
      rdaddr_c   = scan_q;
      done_c     = 1'b0;

      // Scan runs regardless of the write FSM.
      if (tick_q == TICK_LAST) begin
         tick_d = '0;
         scan_d = scan_q + ADDR_W'(1);
      end

      unique case (state_q)
         ST_IDLE: begin
            if (press) begin
               lat_addr_d = addr_s;
               lat_data_d = data_s;
               state_d    = ST_WRITE;
            end
         end
         ST_WRITE: begin
            wren_c   = 1'b1;
            wraddr_c = lat_addr_q;
            wrdata_c = lat_data_q;
`ifdef RAM_ACCESS_VERIFY_EN
            lat_cnt_d = '0;
            state_d   = ST_RDWAIT;
`else
            done_c  = 1'b1;
            state_d = ST_IDLE;
`endif
         end
`ifdef RAM_ACCESS_VERIFY_EN
         ST_RDWAIT: begin
            rdaddr_c = lat_addr_q;
            if (lat_cnt_q == LAT_LAST) begin
               state_d = ST_CHECK;
            end else begin
               lat_cnt_d = lat_cnt_q + LW'(1);
            end
         end
         ST_CHECK: begin
            rdaddr_c = lat_addr_q;
            if (ram_q_i != lat_data_q) begin
               err_d = 1'b1;
            end
            done_c  = 1'b1;
            state_d = ST_IDLE;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (done_c) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   assign ram_wren_o   = wren_c;
   assign ram_wraddr_o = wraddr_c;
   assign ram_wrdata_o = wrdata_c;
   assign ram_rdaddr_o = rdaddr_c;
   assign scan_addr_o  = scan_q;
   assign wr_done_o    = done_c;
   assign wr_count_o   = cnt_q;
`ifdef RAM_ACCESS_VERIFY_EN
   assign verify_err_o = err_q;
`else
   assign verify_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: bench for ram_access_ctrl with a 32x4 RAM model.
// Transaction-level reference model, vector table and corner sequences.
`timescale 1ns/1ps

module tb_ram_access_ctrl;

   localparam int TICK = 4;
   localparam int RDL  = 1;
   localparam logic [4:0] FA = 5'd2;
`ifdef RAM_ACCESS_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       key_n = 1'b1;
   logic [4:0] sw_addr = '0;
   logic [3:0] sw_data = '0;
   logic [3:0] ram_q = '0;
   logic [4:0] ram_wraddr;
   logic [3:0] ram_wrdata;
   logic       ram_wren;
   logic [4:0] ram_rdaddr;
   logic [4:0] scan_addr;
   logic       wr_done;
   logic [7:0] wr_count;
   logic       verify_err;

   always #5 clk = ~clk;

   ram_access_ctrl #(
      .ADDR_W(5), .DATA_W(4), .TICK_DIV(TICK),
      .RD_LAT(RDL), .SYNC_STAGES(2)
   ) dut (
      .clk_i(clk), .reset_i(reset), .key_n_i(key_n),
      .sw_addr_i(sw_addr), .sw_data_i(sw_data), .ram_q_i(ram_q),
      .ram_wraddr_o(ram_wraddr), .ram_wrdata_o(ram_wrdata),
      .ram_wren_o(ram_wren), .ram_rdaddr_o(ram_rdaddr),
      .scan_addr_o(scan_addr), .wr_done_o(wr_done),
      .wr_count_o(wr_count), .verify_err_o(verify_err)
   );

   // RAM model; fault_en forces q=7 when reading address FA
   logic [3:0] mem [32];
   logic       fault_en = 1'b0;
   logic [4:0] cap_a = '0;
   logic [3:0] cap_d = '0;

   always @(posedge clk) begin
      if (ram_wren) begin
         mem[ram_wraddr] <= ram_wrdata;
         cap_a <= ram_wraddr;
         cap_d <= ram_wrdata;
      end
      ram_q <= (fault_en && ram_rdaddr == FA) ? 4'd7 : mem[ram_rdaddr];
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // edges since last reset edge
   int unsigned ecyc = 0;
   always @(posedge clk) begin
      if (reset) ecyc <= 0;
      else       ecyc <= ecyc + 1;
   end

   // ---------------- reference model state ----------------
   typedef struct {
      int unsigned e;
      logic [4:0]  a;
      logic [3:0]  d;
   } wr_ev_t;

   wr_ev_t      wq[$];
   int unsigned dq[$];
   int unsigned idle_from = 0;
   int unsigned rdw_lo = 1;
   int unsigned rdw_hi = 0;
   logic [4:0]  rdw_a = '0;
   int unsigned err_edge = 32'hFFFF_FFFF;
   int unsigned cnt_model = 0;
   int unsigned acc = 0;
   bit          mon_en = 1'b0;

   task automatic model_reset();
      wq.delete();
      dq.delete();
      idle_from = 0;
      rdw_lo    = 1;
      rdw_hi    = 0;
      err_edge  = 32'hFFFF_FFFF;
      cnt_model = 0;
      acc       = 0;
   endtask

   // key_n falls just after edge k: press seen in the cycle after edge k+2,
   // write pulse after edge k+3. Dropped if the controller is busy then.
   task automatic model_press(input int unsigned k, input logic [4:0] a,
                              input logic [3:0] d);
      int unsigned p;
      int unsigned de;
      p = k + 2;
      if (p >= idle_from) begin
         wq.push_back('{p + 1, a, d});
         if (VER) begin
            de     = p + 2 + RDL;
            rdw_lo = p + 2;
            rdw_hi = de;
            rdw_a  = a;
            if (fault_en && a == FA && d != 4'd7 && err_edge > de + 1)
               err_edge = de + 1;
            idle_from = de + 1;
         end else begin
            de        = p + 1;
            idle_from = p + 2;
         end
         dq.push_back(de);
         acc++;
      end
   endtask

   // ---------------- per-cycle monitor ----------------
   int unsigned me;
   logic [4:0]  mscan;
   bit          mwin;

   always @(negedge clk) begin
      if (mon_en && !reset) begin
         me    = ecyc;
         mscan = 5'((me / TICK) % 32);
         mwin  = VER && me >= rdw_lo && me <= rdw_hi;
         chk("scan_addr", scan_addr, mscan);
         chk("ram_rdaddr", ram_rdaddr, mwin ? rdw_a : mscan);
         if (wq.size() > 0 && wq[0].e == me) begin
            chk("wren_pulse", ram_wren, 1);
            chk("wraddr", ram_wraddr, wq[0].a);
            chk("wrdata", ram_wrdata, wq[0].d);
            void'(wq.pop_front());
         end else begin
            chk("wren_idle", ram_wren, 0);
            chk("wraddr_idle", ram_wraddr, 0);
            chk("wrdata_idle", ram_wrdata, 0);
         end
         chk("wr_count", wr_count, cnt_model[7:0]);
         if (dq.size() > 0 && dq[0] == me) begin
            chk("wr_done_pulse", wr_done, 1);
            void'(dq.pop_front());
            cnt_model++;
         end else begin
            chk("wr_done_idle", wr_done, 0);
         end
         chk("verify_err", verify_err, (VER && me >= err_edge) ? 1 : 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_press(input logic [4:0] a, input logic [3:0] d,
                           input int low, input int gap);
      sw_addr = a;
      sw_data = d;
      key_n   = 1'b0;
      model_press(ecyc, a, d);
      wait_edges(low);
      key_n = 1'b1;
      wait_edges(gap);
   endtask

   typedef struct {
      logic [4:0]  a;
      logic [3:0]  d;
      bit          flt;
      int unsigned cnt;
      bit          err;
   } vec_t;

   vec_t vt[7];

   initial begin
      int unsigned c0;
      int          guard;

      // err column applies only with the readback check built in
      vt[0] = '{5'd2,  4'd8,  1'b0, 1, 1'b0};
      vt[1] = '{5'd31, 4'd15, 1'b0, 2, 1'b0};
      vt[2] = '{5'd0,  4'd0,  1'b0, 3, 1'b0};
      vt[3] = '{5'd2,  4'd8,  1'b1, 4, 1'b1};
      vt[4] = '{5'd5,  4'd3,  1'b0, 5, 1'b1};
      vt[5] = '{5'd2,  4'd7,  1'b1, 6, 1'b1};
      vt[6] = '{5'd17, 4'd10, 1'b0, 7, 1'b1};

      for (int i = 0; i < 32; i++) mem[i] = '0;

      // reset state
      wait_edges(3);
      chk("rst_wren", ram_wren, 0);
      chk("rst_wraddr", ram_wraddr, 0);
      chk("rst_wrdata", ram_wrdata, 0);
      chk("rst_rdaddr", ram_rdaddr, 0);
      chk("rst_scan", scan_addr, 0);
      chk("rst_done", wr_done, 0);
      chk("rst_count", wr_count, 0);
      chk("rst_err", verify_err, 0);
      reset = 1'b0;
      model_reset();
      mon_en = 1'b1;

      // scan only: 31 after 124 edges, wraps to 0 at 128
      wait_edges(124);
      chk("scan_at_31", scan_addr, 31);
      wait_edges(4);
      chk("scan_wrap_0", scan_addr, 0);
      chk("scan_no_wren", ram_wren, 0);

      // vector table
      for (int i = 0; i < 7; i++) begin
         fault_en = vt[i].flt;
         do_press(vt[i].a, vt[i].d, 1, 1);
         wait_edges(10);
         chk("tbl_wraddr", cap_a, vt[i].a);
         chk("tbl_wrdata", cap_d, vt[i].d);
         chk("tbl_count", wr_count, vt[i].cnt);
         chk("tbl_err", verify_err, (VER && vt[i].err) ? 1 : 0);
      end
      fault_en = 1'b0;

      // second key edge while the first write is still being verified
      c0 = acc;
      do_press(5'd12, 4'd3, 1, 1);
      do_press(5'd13, 4'd4, 1, 10);
      chk("drop_second", wr_count, 8'(c0 + (VER ? 1 : 2)));

      // random traffic through the 255->0 count wrap
      guard = 0;
      while (acc < 270 && guard < 3000) begin
         do_press(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
                  $urandom_range(1, 3), $urandom_range(1, 4));
         guard++;
      end
      wait_edges(10);
      chk("count_wrap", wr_count, 8'(acc));
      chk("rand_idle_wren", ram_wren, 0);

      // reset while in WRITE with key held low
      c0 = ecyc;
      sw_addr = 5'd9;
      sw_data = 4'd6;
      key_n   = 1'b0;
      model_press(c0, 5'd9, 4'd6);
      wait_edges(3);
      chk("pre_rst_wren", ram_wren, 1);
      chk("pre_rst_wraddr", ram_wraddr, 9);
      mon_en = 1'b0;
      reset  = 1'b1;
      model_reset();
      wait_edges(1);
      chk("rst_write_wren", ram_wren, 0);
      chk("rst_write_count", wr_count, 0);
      chk("rst_write_scan", scan_addr, 0);
      chk("rst_write_err", verify_err, 0);
      chk("rst_write_rdaddr", ram_rdaddr, 0);
      wait_edges(2);
      reset  = 1'b0;
      mon_en = 1'b1;
      wait_edges(20);
      chk("held_key_nowrite", wr_count, 0);
      key_n = 1'b1;
      wait_edges(3);
      do_press(5'd4, 4'd5, 1, 1);
      wait_edges(10);
      chk("rearm_write", wr_count, 1);
      chk("rearm_wraddr", cap_a, 4);
      chk("rearm_wrdata", cap_d, 5);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
